// File: rtl/mig_line_reader_pkg.sv
// Shared MIG command encodings and the read-master state type.
package mig_pkg;

    localparam logic [2:0] MIG_CMD_READ  = 3'b001;
    localparam logic [2:0] MIG_CMD_WRITE = 3'b000;

    typedef enum logic [2:0] {
        WAIT_CAL,
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } rd_state_t;

endpackage

// File: rtl/mig_line_reader_if.sv
// APP-side signals of the MIG native user interface (read master = master modport).
interface mig_line_reader_if #(
    parameter int DW = 128,
    parameter int AW = 30
);
    logic [AW-1:0]   app_addr;
    logic [2:0]      app_cmd;
    logic            app_en;
    logic            app_rdy;
    logic [DW-1:0]   app_rd_data;
    logic            app_rd_data_valid;
    logic            app_rd_data_end;
    logic            init_calib_complete;
    logic            app_wdf_wren;
    logic            app_wdf_end;
    logic [DW-1:0]   app_wdf_data;
    logic [DW/8-1:0] app_wdf_mask;
    logic            app_ref_req;
    logic            app_zq_req;

    modport master (
        output app_addr, app_cmd, app_en, app_wdf_wren, app_wdf_end,
               app_wdf_data, app_wdf_mask, app_ref_req, app_zq_req,
        input  app_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
               init_calib_complete
    );

    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_wren, app_wdf_end,
               app_wdf_data, app_wdf_mask, app_ref_req, app_zq_req,
        output app_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
               init_calib_complete
    );
endinterface

// File: rtl/mig_rd_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is visible whenever empty=0.
module mig_rd_fifo #(
    parameter int DW         = 128,
    parameter int FIFO_DEPTH = 32,
    localparam int PW        = $clog2(FIFO_DEPTH),
    localparam int CW        = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push, do_pop;

    assign full    = (count_reg == CW'(FIFO_DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

    assign pop_data = mem[rd_ptr_reg];
    assign count    = count_reg;
endmodule

// File: rtl/mig_line_reader.sv
// MIG read master: splits a burst request into single-beat READs, buffers returned beats.
// Optional MIG_LINE_READER_STATS_EN adds saturating stall_cnt / credit_stall_cnt outputs.
module mig_line_reader
    import mig_pkg::*;
#(
    parameter int DW         = 128,
    parameter int AW         = 30,
    parameter int ADDR_INC   = 8,
    parameter int FIFO_DEPTH = 32,
    parameter int BEAT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [AW-1:0]     req_addr,
    input  logic [BEAT_W-1:0] req_beats,
    output logic              busy,
    output logic              done,
    mig_line_reader_if.master mig,
    output logic [DW-1:0]     out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef MIG_LINE_READER_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       credit_stall_cnt
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    rd_state_t         state_reg, state_next;
    logic              app_en_reg, app_en_next;
    logic [AW-1:0]     app_addr_reg, app_addr_next;
    logic [BEAT_W-1:0] cmds_left_reg, cmds_left_next;
    logic [BEAT_W-1:0] beats_left_reg, beats_left_next;
    logic [CW-1:0]     outstanding_reg, outstanding_next;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       reserved;
    logic              room, cmd_accept, push, pop, fifo_full, fifo_empty, req_fire;

    assign cmd_accept = app_en_reg && mig.app_rdy;
    // A beat with nothing outstanding is stale (e.g. issued before a reset) and is dropped.
    assign push       = mig.app_rd_data_valid && (outstanding_reg != '0);
    assign pop        = out_valid && out_ready;
    assign req_fire   = req_valid && req_ready;
    // A pending (not yet accepted) command already holds its FIFO slot.
    assign reserved   = {1'b0, fifo_count} + {1'b0, outstanding_reg} + {{CW{1'b0}}, app_en_reg};
    assign room       = reserved < (CW+1)'(FIFO_DEPTH);

    always_comb begin
        state_next       = state_reg;
        app_en_next      = app_en_reg;
        app_addr_next    = app_addr_reg;
        cmds_left_next   = cmds_left_reg;
        beats_left_next  = beats_left_reg;
        outstanding_next = outstanding_reg;
        case ({cmd_accept, push})
            2'b10:   outstanding_next = outstanding_reg + CW'(1);
            2'b01:   outstanding_next = outstanding_reg - CW'(1);
            default: outstanding_next = outstanding_reg;
        endcase
        if (push && beats_left_reg != '0) beats_left_next = beats_left_reg - BEAT_W'(1);
        case (state_reg)
            WAIT_CAL: if (mig.init_calib_complete) state_next = IDLE;
            IDLE: begin
                if (req_fire) begin
                    app_addr_next   = req_addr;
                    cmds_left_next  = req_beats;
                    beats_left_next = req_beats;
                    app_en_next     = (req_beats != '0) && room;
                    state_next      = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_accept) begin
                    app_addr_next  = app_addr_reg + AW'(ADDR_INC);
                    cmds_left_next = cmds_left_reg - BEAT_W'(1);
                end
                if (!app_en_reg || mig.app_rdy) app_en_next = (cmds_left_next != '0) && room;
                if (cmds_left_reg == '0)       state_next = FINISH;
                else if (cmds_left_next == '0) state_next = DRAIN;
            end
            DRAIN:   if (beats_left_reg == '0) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = WAIT_CAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= WAIT_CAL;
            app_en_reg      <= 1'b0;
            app_addr_reg    <= '0;
            cmds_left_reg   <= '0;
            beats_left_reg  <= '0;
            outstanding_reg <= '0;
        end else begin
            state_reg       <= state_next;
            app_en_reg      <= app_en_next;
            app_addr_reg    <= app_addr_next;
            cmds_left_reg   <= cmds_left_next;
            beats_left_reg  <= beats_left_next;
            outstanding_reg <= outstanding_next;
        end
    end

    mig_rd_fifo #(.DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (mig.app_rd_data),
        .pop       (pop),
        .pop_data  (out_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid        = !fifo_empty;
    assign req_ready        = (state_reg == IDLE);
    assign busy             = (state_reg == ISSUE) || (state_reg == DRAIN);
    assign done             = (state_reg == FINISH);
    assign mig.app_en       = app_en_reg;
    assign mig.app_addr     = app_addr_reg;
    assign mig.app_cmd      = MIG_CMD_READ;
    assign mig.app_wdf_wren = 1'b0;
    assign mig.app_wdf_end  = 1'b0;
    assign mig.app_wdf_data = '0;
    assign mig.app_wdf_mask = '0;
    assign mig.app_ref_req  = 1'b0;
    assign mig.app_zq_req   = 1'b0;

    push_never_full: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));
    end_with_valid:  assert property (@(posedge clk) disable iff (rst)
                                      mig.app_rd_data_end |-> mig.app_rd_data_valid);

`ifdef MIG_LINE_READER_STATS_EN
    logic [31:0] stall_cnt_reg, credit_stall_cnt_reg;
    logic [CW:0] used_now;
    logic        credit_zero;

    assign used_now    = {1'b0, fifo_count} + {1'b0, outstanding_reg};
    assign credit_zero = used_now >= (CW+1)'(FIFO_DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg        <= '0;
            credit_stall_cnt_reg <= '0;
        end else begin
            if (app_en_reg && !mig.app_rdy && stall_cnt_reg != '1)
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            if (state_reg == ISSUE && cmds_left_reg != '0 && credit_zero && credit_stall_cnt_reg != '1)
                credit_stall_cnt_reg <= credit_stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt        = stall_cnt_reg;
    assign credit_stall_cnt = credit_stall_cnt_reg;
`endif
endmodule

// File: tb/tb_mig_line_reader.sv
// Directed bench: MIG model with fixed read latency, scoreboarded output stream.
module tb_mig_line_reader;
    localparam int DW  = 128;
    localparam int AW  = 30;
    localparam int LAT = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic [15:0]   req_beats = '0;
    logic          busy, done;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
`ifdef MIG_LINE_READER_STATS_EN
    logic [31:0]   stall_cnt, credit_stall_cnt;
`endif

    mig_line_reader_if #(.DW(DW), .AW(AW)) mig();

    mig_line_reader dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_beats (req_beats),
        .busy      (busy),
        .done      (done),
        .mig       (mig),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MIG_LINE_READER_STATS_EN
        ,
        .stall_cnt        (stall_cnt),
        .credit_stall_cnt (credit_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [DW-1:0] data; } ret_t;
    typedef struct {
        logic [AW-1:0] addr;
        int            beats;
        int            rdy_mode;
        bit            bp;
        logic [AW-1:0] exp_last;
    } vec_t;

    ret_t          ret_q[$];
    logic [AW-1:0] acc_q[$];
    logic [DW-1:0] exp_q[$];
    vec_t          vecs[4];

    int checks = 0, errors = 0;
    int cyc = 0, rdy_mode = 0;
    bit out_ready_on = 1'b1;
    int done_cnt = 0, stab_err = 0, en_cycles = 0, valid_seen = 0, beats_out = 0;
    bit prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        return {2'b10, a, 2'b01, ~a, 2'b11, a, 2'b00, a ^ 30'h155AA};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"}, DW'(req_ready), 0);
        check({tag, "_busy"}, DW'(busy), 0);
        check({tag, "_done"}, DW'(done), 0);
        check({tag, "_app_en"}, DW'(mig.app_en), 0);
        check({tag, "_app_addr"}, DW'(mig.app_addr), 0);
        check({tag, "_out_valid"}, DW'(out_valid), 0);
    endtask

    task automatic start_burst(input logic [AW-1:0] a, input int n);
        int w = 0;
        while (!req_ready && w < 200) begin tick(); w++; end
        check("req_ready_wait", DW'(req_ready), 1);
        for (int i = 0; i < n; i++) exp_q.push_back(data_of(a + AW'(i * 8)));
        req_valid = 1'b1;
        req_addr  = a;
        req_beats = 16'(n);
        tick();
        req_valid = 1'b0;
    endtask

    // MIG model, stream consumer and protocol monitors, all evaluated mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            mig.app_rd_data_valid = 1'b1;
            mig.app_rd_data_end   = 1'b1;
            mig.app_rd_data       = ret_q[0].data;
            void'(ret_q.pop_front());
        end else begin
            mig.app_rd_data_valid = 1'b0;
            mig.app_rd_data_end   = 1'b0;
        end
        mig.app_rdy = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        out_ready   = out_ready_on;
        if (prev_stall && (mig.app_en !== 1'b1 || mig.app_addr !== prev_addr)) stab_err++;
        prev_stall = !rst && mig.app_en && !mig.app_rdy;
        prev_addr  = mig.app_addr;
        if (mig.app_en) en_cycles++;
        if (!rst && mig.app_en && mig.app_rdy) begin
            acc_q.push_back(mig.app_addr);
            ret_q.push_back('{cyc + LAT, data_of(mig.app_addr)});
        end
        if (done) done_cnt++;
        if (out_valid) valid_seen++;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got 0x%0h, expected no beat", out_data);
            end else begin
                check("beat_data", out_data, exp_q.pop_front());
                beats_out++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int gate_err, w, addr_err;
        logic [AW-1:0] last;

        mig.app_rdy             = 1'b0;
        mig.app_rd_data_valid   = 1'b0;
        mig.app_rd_data_end     = 1'b0;
        mig.app_rd_data         = '0;
        mig.init_calib_complete = 1'b0;
        out_ready               = 1'b0;

        vecs[0] = '{30'h100,      4,   0, 1'b0, 30'h118};
        vecs[1] = '{30'h3FFFFFF8, 2,   0, 1'b0, 30'h0};
        vecs[2] = '{30'h2000,     17,  1, 1'b0, 30'h2080};
        vecs[3] = '{30'h200,      100, 0, 1'b1, 30'h518};

        repeat (3) tick();
        check_reset_values("reset");

        // Calibration gating with a zero-beat request held pending.
        rst       = 1'b0;
        req_valid = 1'b1;
        req_addr  = 30'h40;
        req_beats = 16'd0;
        en_cycles = 0;
        done_cnt  = 0;
        gate_err  = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (req_ready || mig.app_en) gate_err++;
        end
        check("calib_gate", DW'(gate_err), 0);
        mig.init_calib_complete = 1'b1;
        tick();
        check("req_ready_after_cal", DW'(req_ready), 1);
        tick();
        req_valid = 1'b0;
        check("zero_busy", DW'(busy), 1);
        check("zero_done_early", DW'(done), 0);
        tick();
        check("zero_done", DW'(done), 1);
        check("zero_busy_finish", DW'(busy), 0);
        tick();
        check("zero_done_once", DW'(done), 0);
        check("zero_req_ready", DW'(req_ready), 1);
        check("zero_no_app_en", DW'(en_cycles), 0);
        check("zero_done_count", DW'(done_cnt), 1);
        $display("zero-beat request: done_count=%0d app_en_cycles=%0d", done_cnt, en_cycles);

        // Reset in the middle of a 40-beat burst.
        rdy_mode = 0;
        acc_q.delete();
        start_burst(30'h4000, 40);
        w = 0;
        while (acc_q.size() < 10 && w < 200) begin tick(); w++; end
        check("mid_burst_progress", DW'(acc_q.size() >= 10), 1);
        rst = 1'b1;
        tick();
        check_reset_values("midrst");
        rst = 1'b0;
        exp_q.delete();
        valid_seen = 0;
        en_cycles  = 0;
        repeat (50) tick();
        check("late_beat_dropped", DW'(valid_seen), 0);
        check("no_cmd_after_reset", DW'(en_cycles), 0);
        check("idle_after_reset", DW'(req_ready), 1);
        $display("reset mid-burst: cmds_before_reset=%0d out_valid_cycles_after=%0d", acc_q.size(), valid_seen);

        foreach (vecs[k]) begin
            acc_q.delete();
            exp_q.delete();
            done_cnt     = 0;
            stab_err     = 0;
            beats_out    = 0;
            rdy_mode     = vecs[k].rdy_mode;
            out_ready_on = !vecs[k].bp;
            start_burst(vecs[k].addr, vecs[k].beats);
            check("first_app_en", DW'(mig.app_en), 1);
            if (vecs[k].bp) begin
                repeat (150) tick();
                check("bp_cmd_count", DW'(acc_q.size()), 32);
                check("bp_app_en_low", DW'(mig.app_en), 0);
                out_ready_on = 1'b1;
            end
            w = 0;
            while ((done_cnt == 0 || exp_q.size() != 0) && w < 5000) begin tick(); w++; end
            check("burst_timeout", DW'(w < 5000), 1);
            repeat (3) tick();
            addr_err = 0;
            foreach (acc_q[i]) if (acc_q[i] !== vecs[k].addr + AW'(i * 8)) addr_err++;
            last = (acc_q.size() > 0) ? acc_q[acc_q.size() - 1] : '1;
            check("cmd_count", DW'(acc_q.size()), DW'(vecs[k].beats));
            check("last_addr", DW'(last), DW'(vecs[k].exp_last));
            check("addr_sequence", DW'(addr_err), 0);
            check("beats_out", DW'(beats_out), DW'(vecs[k].beats));
            check("done_pulses", DW'(done_cnt), 1);
            check("app_en_stable", DW'(stab_err), 0);
            check("busy_after", DW'(busy), 0);
            $display("burst %0d: addr=0x%0h beats=%0d cmds=%0d last=0x%0h delivered=%0d done=%0d",
                     k, vecs[k].addr, vecs[k].beats, acc_q.size(), last, beats_out, done_cnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
